line_mem_responder: RTL
=======================

LINE_MEM_RESPONDER -- requirements
Module: line_mem_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 10: cycles from request acceptance to ack_o, legal range 2..15.
REQ-002 SHALL have parameter DEPTH, default 512: number of 256-bit lines.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port addr_i, input, 32 bits: byte address; line index = addr_i[13:5], bits [4:0] ignored.
REQ-006 SHALL have port data_i, input, 256 bits: write line data.
REQ-007 SHALL have port enable_i, input, 1 bit: request valid, held by the initiator until ack_o.
REQ-008 SHALL have port write_i, input, 1 bit: 1 = line write, 0 = line read.
REQ-009 SHALL have port ack_o, output, 1 bit: one-cycle completion pulse.
REQ-010 SHALL have port data_o, output, 256 bits: read line data, valid when ack_o=1 on a read.

Function
REQ-011 SHALL implement FSM states IDLE, WAIT and ACK.
REQ-012 In IDLE with enable_i=1, SHALL latch addr_i, data_i and write_i, load the counter with LATENCY-2, and enter WAIT.
REQ-013 In WAIT, SHALL decrement the 4-bit counter each cycle and enter ACK on the cycle after the counter reaches 0.
REQ-014 ack_o SHALL be 1 only in ACK, giving exactly LATENCY cycles from the accepting edge to the ack_o=1 edge.
REQ-015 ACK SHALL unconditionally return to IDLE; no request is accepted in ACK, so back-to-back requests have a 1-cycle gap.
REQ-016 On a read, data_o SHALL present line[idx] during the ACK cycle and hold that value until the next read ACK.
REQ-017 On a write, SHALL commit the latched data_i to line[idx] on the edge leaving ACK; data_o is unchanged.
REQ-018 Inputs changing or enable_i dropping during WAIT SHALL be ignored; the latched transaction completes and acks.
REQ-019 A read that immediately follows a write to the same line SHALL return the newly written data.
REQ-020 Index wrap: addresses with addr_i[31:14] nonzero SHALL alias modulo DEPTH (when the REQ-027 check is absent).

Reset
REQ-021 rst_i=0 SHALL asynchronously force state to IDLE, the counter to 0, ack_o to 0 and data_o to 0.
REQ-022 Reset during WAIT or ACK SHALL abort the transaction with no array write and no ack.
REQ-023 Reset SHALL NOT clear the storage array; the array is initialized only by hierarchical preload.
REQ-024 The first request SHALL be accepted on the first rising edge with rst_i=1 and enable_i=1.

Configuration
REQ-025 Macro LINE_MEM_RANGE_CHECK_EN SHALL select the address-range check.
REQ-026 Without LINE_MEM_RANGE_CHECK_EN, there SHALL be no err_o port and REQ-020 aliasing applies.
REQ-027 With LINE_MEM_RANGE_CHECK_EN, SHALL add output err_o (1 bit, reset 0), pulsed with ack_o when the latched addr[31:14] is nonzero.
REQ-028 With LINE_MEM_RANGE_CHECK_EN, an erroring write SHALL be suppressed, and an erroring read SHALL return all-zero data_o.

Structure
REQ-029 Package line_mem_pkg SHALL hold LINE_W=256, ADDR_W=32, IDX_W=9, OFFSET_W=5, CNT_W=4 and the FSM state enum.
REQ-030 Sub-module line_mem_array SHALL hold the DEPTH x LINE_W storage with one write port and one read port; storage is named memory for preload and flush access.
REQ-031 The FSM, counter and latches SHALL reside in line_mem_responder.

Verification
REQ-032 Reset/idle: hold rst_i=0 for 2 cycles, then enable_i=0 for 20 cycles -> ack_o=0 and data_o=0 throughout.
REQ-033 Read latency: preload line 0 = 0000_1111_..._FFFF, read addr 0x0000 -> ack_o on exactly the 10th edge after acceptance, with data_o equal to the preloaded line.
REQ-034 Write then read: write ECFA repeated to 0x0040, then read 0x0040 -> data matches; line 1 (0x0020) is unchanged.
REQ-035 Robustness: drop enable_i and change addr_i during WAIT -> a single ack_o still occurs, using the original address.
REQ-036 Reset mid-op: assert rst_i=0 at cycle 5 of a write to 0x0200 -> no ack, line 16 unchanged, and the next read is accepted normally.
REQ-037 Range check: write to 0x0001_0000 -> with LINE_MEM_RANGE_CHECK_EN, err_o=1 at ack and line 0 is unchanged; without it, line 0 is overwritten.

Source files
------------

// File: rtl/line_mem_pkg.sv
// Purpose : shared widths and FSM state encoding for the line memory responder.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package line_mem_pkg;
  localparam int LINE_W   = 256;
  localparam int ADDR_W   = 32;
  localparam int IDX_W    = 9;
  localparam int OFFSET_W = 5;
  localparam int CNT_W    = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_e;
endpackage

// File: rtl/line_mem_array.sv
// Purpose : DEPTH x LINE_W line storage, one synchronous write port, one combinational read port.
// Latency : write commits on the clock edge; read data follows rd_idx_i in the same cycle.
// Backpressure: none, every write is taken.
// Ports   : clk_i; wr_en_i/wr_idx_i/wr_dat_i write port; rd_idx_i/rd_dat_o read port.
// The storage array is named memory so a bench can preload or inspect it by hierarchy.
// It has no reset, so its contents survive a reset.
module line_mem_array
  import line_mem_pkg::*;
#(
  parameter int DEPTH = 512
) (
  input  logic              clk_i,
  input  logic              wr_en_i,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic [LINE_W-1:0] wr_dat_i,
  input  logic [IDX_W-1:0]  rd_idx_i,
  output logic [LINE_W-1:0] rd_dat_o
);
  // DEPTH is a power of two; the low index bits select the line, so
  // larger indices alias modulo DEPTH.
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [LINE_W-1:0] memory [DEPTH];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      memory[wr_idx_i[AW-1:0]] <= wr_dat_i;
    end
  end

  assign rd_dat_o = memory[rd_idx_i[AW-1:0]];
endmodule

// File: rtl/line_mem_responder.sv
// Purpose : fixed-latency 256-bit line read/write responder in front of line_mem_array.
// Latency : ack_o rises exactly LATENCY clock edges after the edge that accepts a request.
// Backpressure: one request at a time; enable_i is held until ack_o, no acceptance in WAIT or ACK.
// Ports   : clk_i, rst_i (async active-low); addr_i/data_i/enable_i/write_i request;
//           ack_o one-cycle completion, data_o read data (held until the next read ack).
// Macro LINE_MEM_RANGE_CHECK_EN adds err_o and blocks accesses with addr[31:14] != 0;
// without it, those addresses alias onto the array.
module line_mem_responder
  import line_mem_pkg::*;
#(
  parameter int LATENCY = 10,
  parameter int DEPTH   = 512
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [LINE_W-1:0] data_i,
  input  logic              enable_i,
  input  logic              write_i,
  output logic              ack_o,
  output logic [LINE_W-1:0] data_o
`ifdef LINE_MEM_RANGE_CHECK_EN
  ,
  output logic              err_o
`endif
);
  localparam logic [CNT_W-1:0] CNT_LOAD    = CNT_W'(LATENCY - 2);
  // The counter keeps decrementing past zero; seeing it wrap to all-ones
  // marks the cycle after it reached zero, which is when WAIT ends.
  localparam logic [CNT_W-1:0] CNT_EXPIRED = '1;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdat_q, wdat_d;
  logic              write_q, write_d;
  logic [LINE_W-1:0] data_q, data_d;

  logic [IDX_W-1:0]  idx;
  logic [LINE_W-1:0] rd_dat;
  logic              mem_we;
  logic              range_err;
  logic              unused_addr;

  assign idx = addr_q[OFFSET_W +: IDX_W];

`ifdef LINE_MEM_RANGE_CHECK_EN
  assign range_err   = |addr_q[ADDR_W-1:OFFSET_W+IDX_W];
  assign unused_addr = ^addr_q[OFFSET_W-1:0];
  assign err_o       = (state_q == ACK) && range_err;
`else
  assign range_err   = 1'b0;
  assign unused_addr = ^{addr_q[ADDR_W-1:OFFSET_W+IDX_W], addr_q[OFFSET_W-1:0]};
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdat_d  = wdat_q;
    write_d = write_q;
    data_d  = data_q;
    mem_we  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable_i) begin
          addr_d  = addr_i;
          wdat_d  = data_i;
          write_d = write_i;
          cnt_d   = CNT_LOAD;
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_EXPIRED) begin
          cnt_d   = '0;
          state_d = ACK;
          // Read data is captured on the edge entering ACK so it is
          // visible for the whole ACK cycle and held afterwards.
          if (!write_q) begin
            data_d = range_err ? '0 : rd_dat;
          end
        end
      end
      ACK: begin
        // Write lands on the edge leaving ACK; a reset in ACK kills it.
        mem_we  = write_q && !range_err;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdat_q  <= '0;
      write_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      write_q <= write_d;
      data_q  <= data_d;
    end
  end

  assign ack_o  = (state_q == ACK);
  assign data_o = data_q;

  line_mem_array #(
    .DEPTH (DEPTH)
  ) u_array (
    .clk_i    (clk_i),
    .wr_en_i  (mem_we),
    .wr_idx_i (idx),
    .wr_dat_i (wdat_q),
    .rd_idx_i (idx),
    .rd_dat_o (rd_dat)
  );
endmodule
